tx_frame_ctrl: RTL and testbench

Transmit-side sequencer for the 8-bit combinational encoder in the transmitter–receiver system. It accepts a byte from upstream with a valid/ready handshake and drives it into the encoder. It then captures the encoded byte and serialises it onto the line as a framed word: start bit, 8 data bits MSB-first, even-parity bit, stop bit. It sits between the byte source and the physical line, owning the encoder's input and sampling its output.

---
 rtl/tx_frame_ctrl.sv | 107 ++++++++++
 tb/tb_tx_frame_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_ctrl.sv
// Transmit sequencer: accepts a byte, drives it through the external encoder,
// then serialises the encoded byte as start, 8 data bits MSB-first, even parity, stop.
module tx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] enc_in,
    input  logic [7:0] enc_out,
    output logic       tx_line,
    output logic       busy,
    output logic       done
);

    // state  | meaning
    // IDLE   | line high, waiting for a byte
    // ENCODE | enc_in stable for one cycle, encoder output captured at its end
    // START  | line low for one bit time
    // DATA   | eight encoded bits, MSB first
    // PARITY | even-parity bit over the data
    // STOP   | line high for one bit time, done in its last cycle
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ENCODE = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    logic [2:0]    r_state;
    logic [7:0]    r_enc_in;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [2:0]    r_bit_cnt;
    logic [CW-1:0] r_clk_cnt;
    logic          w_bit_end;

    assign w_bit_end = (r_clk_cnt == LAST_CLK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_enc_in  <= 8'h00;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
            r_bit_cnt <= 3'd0;
            r_clk_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_enc_in <= in_data;
                        r_state  <= ENCODE;
                    end
                end
                ENCODE: begin
                    r_shift   <= enc_out;
                    r_par     <= ^enc_out;
                    r_bit_cnt <= 3'd0;
                    r_clk_cnt <= '0;
                    r_state   <= START;
                end
                START, DATA, PARITY, STOP: begin
                    r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
                    if (w_bit_end) begin
                        case (r_state)
                            START:  r_state <= DATA;
                            DATA: begin
                                if (r_bit_cnt == 3'd7) begin
                                    r_state <= PARITY;
                                end else begin
                                    r_shift   <= {r_shift[6:0], 1'b0};
                                    r_bit_cnt <= r_bit_cnt + 3'd1;
                                end
                            end
                            PARITY: r_state <= STOP;
                            default: r_state <= IDLE;
                        endcase
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line and status are decoded from registered state only.
    always_comb begin
        tx_line = 1'b1;
        case (r_state)
            START:   tx_line = 1'b0;
            DATA:    tx_line = r_shift[7];
            PARITY:  tx_line = r_par;
            default: tx_line = 1'b1;
        endcase
    end

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == STOP) && w_bit_end;
    assign enc_in   = r_enc_in;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed bench for tx_frame_ctrl: N=4 instance for most cases, N=1 instance
// for the single-cycle bit case. Encoder stub is a bitwise inversion.
module tb_tx_frame_ctrl;

    logic       clk;
    logic       reset;

    logic [7:0] in_data4, enc_in4, enc_out4;
    logic       in_valid4, in_ready4, tx_line4, busy4, done4;
    logic [7:0] in_data1, enc_in1, enc_out1;
    logic       in_valid1, in_ready1, tx_line1, busy1, done1;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc_q[$];

    tx_frame_ctrl #(.CLKS_PER_BIT(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data4),
        .in_valid (in_valid4),
        .in_ready (in_ready4),
        .enc_in   (enc_in4),
        .enc_out  (enc_out4),
        .tx_line  (tx_line4),
        .busy     (busy4),
        .done     (done4)
    );

    tx_frame_ctrl #(.CLKS_PER_BIT(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data1),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .enc_in   (enc_in1),
        .enc_out  (enc_out1),
        .tx_line  (tx_line1),
        .busy     (busy1),
        .done     (done1)
    );

    assign enc_out4 = enc_in4 ^ 8'hFF;
    assign enc_out1 = enc_in1 ^ 8'hFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid4 && in_ready4) acc_q.push_back(cyc);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic f_tx(input int sel);
        return (sel == 1) ? tx_line1 : tx_line4;
    endfunction
    function automatic logic f_rdy(input int sel);
        return (sel == 1) ? in_ready1 : in_ready4;
    endfunction
    function automatic logic f_busy(input int sel);
        return (sel == 1) ? busy1 : busy4;
    endfunction
    function automatic logic f_done(input int sel);
        return (sel == 1) ? done1 : done4;
    endfunction
    function automatic logic [7:0] f_enc(input int sel);
        return (sel == 1) ? enc_in1 : enc_in4;
    endfunction

    // Called #1 after the accept edge; returns at the negedge of the first IDLE cycle.
    task automatic check_frame(input int sel, input int n, input logic [7:0] exp_enc,
                               input logic [7:0] exp_line, input logic exp_par,
                               input string tag);
        logic [10:0] seq;
        seq = {1'b0, exp_line, exp_par, 1'b1};
        @(negedge clk);
        chk({tag, "_enc"},  32'(f_enc(sel)),  32'(exp_enc));
        chk({tag, "_rdy0"}, 32'(f_rdy(sel)),  32'd0);
        chk({tag, "_busy"}, 32'(f_busy(sel)), 32'd1);
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                chk($sformatf("%s_bit%0d_c%0d", tag, b, c), 32'(f_tx(sel)), 32'(seq[10-b]));
                chk($sformatf("%s_done%0d_c%0d", tag, b, c), 32'(f_done(sel)),
                    32'((b == 10) && (c == n - 1)));
                chk($sformatf("%s_rdy%0d_c%0d", tag, b, c), 32'(f_rdy(sel)), 32'd0);
            end
        end
        chk({tag, "_enc_hold"}, 32'(f_enc(sel)), 32'(exp_enc));
        @(negedge clk);
        chk({tag, "_end_rdy"},  32'(f_rdy(sel)),  32'd1);
        chk({tag, "_end_busy"}, 32'(f_busy(sel)), 32'd0);
        chk({tag, "_end_done"}, 32'(f_done(sel)), 32'd0);
        chk({tag, "_end_tx"},   32'(f_tx(sel)),   32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid4 = 1'b0;
        in_data4  = 8'h00;
        in_valid1 = 1'b0;
        in_data1  = 8'h00;
        #22 reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_tx",   32'(tx_line4),  32'd1);
            chk("idle_rdy",  32'(in_ready4), 32'd1);
            chk("idle_busy", 32'(busy4),     32'd0);
            chk("idle_done", 32'(done4),     32'd0);
            chk("idle_enc",  32'(enc_in4),   32'h00);
        end

        // 2: single byte 5B -> A4, parity 1
        @(posedge clk); #1;
        in_data4 = 8'h5B; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        check_frame(0, 4, 8'h5B, 8'hA4, 1'b1, "f5B");

        // 3: back-to-back with in_valid held high
        @(posedge clk); #1;
        acc_q.delete();
        in_data4 = 8'h73; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_data4 = 8'hFF;
        check_frame(0, 4, 8'h73, 8'h8C, 1'b1, "f73");
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        check_frame(0, 4, 8'hFF, 8'h00, 1'b0, "fFF");
        chk("b2b_accepts", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2)
            chk("b2b_spacing", 32'(acc_q[1] - acc_q[0]), 32'd46);

        // 4: input noise during a frame; 3C -> C3, parity 0
        @(posedge clk); #1;
        in_data4 = 8'h3C; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        fork
            check_frame(0, 4, 8'h3C, 8'hC3, 1'b0, "f3C");
            begin
                repeat (40) begin
                    @(posedge clk); #2;
                    in_valid4 = 1'($urandom_range(0, 1));
                    in_data4  = 8'($urandom);
                end
                in_valid4 = 1'b0;
            end
        join

        // 5: reset during data bit 3 (cycle k+19), then a clean frame
        @(posedge clk); #1;
        in_data4 = 8'h5B; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        chk("rst_pre_tx", 32'(tx_line4), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("rst_tx",   32'(tx_line4),  32'd1);
        chk("rst_rdy",  32'(in_ready4), 32'd1);
        chk("rst_busy", 32'(busy4),     32'd0);
        chk("rst_done", 32'(done4),     32'd0);
        chk("rst_enc",  32'(enc_in4),   32'h00);
        #3 reset = 1'b0;
        @(posedge clk); #1;
        in_data4 = 8'h00; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        check_frame(0, 4, 8'h00, 8'hFF, 1'b0, "f00");

        // 6: one clock per bit, 0F -> F0, parity 0
        @(posedge clk); #1;
        in_data1 = 8'h0F; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check_frame(1, 1, 8'h0F, 8'hF0, 1'b0, "n1_0F");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
